// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture block.
// Holds the abcdefg digit patterns (bit6 = a .. bit0 = g, 1 = lit), the
// geometry constants, the capture FSM state type and the registered
// input sample layout.
package seg7_pkg;

    localparam int SEG_W      = 7;
    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;

    typedef enum logic [1:0] {
        WAIT,
        SETTLE,
        HOLD
    } state_e;

    // en[3] is digit 1 (leftmost) so it lines up with the slot numbering.
    typedef struct packed {
        logic [NUM_DIGITS-1:0] en;
        logic [SEG_W-1:0]      pat;
        logic                  dp;
    } sample_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to BCD decoder.
// Ports:
//   pattern - abcdefg segment pattern, 1 = lit
//   bcd     - decoded digit, BCD_INVALID when the pattern is not a digit
//   err     - 1 when the pattern is not one of the ten digit shapes
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [3:0]       bcd,
    output logic             err
);

    always_comb begin
        bcd = BCD_INVALID;
        err = 1'b0;
        case (pattern)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/segment_scan_capture.sv
// Loopback reader for a 4-digit 7-segment display bus.
// Registers the digit enables, segment bus and decimal point once per clock,
// waits for each (select, pattern) pair to be stable for STABLE_CYCLES
// edges, then captures it into the selected digit slot(s). When all four
// slots have been captured the frame is published and frame_valid pulses.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   segment1..segment4            - digit enables (1 = leftmost), active high
//   segmentShow, dp               - shared abcdefg bus and decimal point
//   bcd_out, dp_out, digit_err    - last complete frame, digit 1 in the MSBs
//   frame_valid                   - one-cycle pulse when the frame updates
module segment_scan_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  segment1,
    input  logic                  segment2,
    input  logic                  segment3,
    input  logic                  segment4,
    input  logic [SEG_W-1:0]      segmentShow,
    input  logic                  dp,
    output logic [15:0]           bcd_out,
    output logic [NUM_DIGITS-1:0] dp_out,
    output logic [NUM_DIGITS-1:0] digit_err,
    output logic                  frame_valid
);

    sample_t s_d, s_q;
    state_e  state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic cap;

    logic [NUM_DIGITS-1:0][3:0] slot_bcd_d, slot_bcd_q;
    logic [NUM_DIGITS-1:0]      slot_err_d, slot_err_q;
    logic [NUM_DIGITS-1:0]      slot_dp_d,  slot_dp_q;
    logic [NUM_DIGITS-1:0]      mask_d,     mask_q;

    logic [NUM_DIGITS-1:0][3:0] out_bcd_d, out_bcd_q;
    logic [NUM_DIGITS-1:0]      out_err_d, out_err_q;
    logic [NUM_DIGITS-1:0]      out_dp_d,  out_dp_q;
    logic                       fv_d,      fv_q;

    logic [3:0] dec_bcd;
    logic       dec_err;

    // Single digit select or all-digit broadcast; anything else is idle.
    function automatic logic is_active(input logic [NUM_DIGITS-1:0] en);
        return $onehot(en) || (en == {NUM_DIGITS{1'b1}});
    endfunction

    assign s_d = '{en: {segment1, segment2, segment3, segment4},
                   pat: segmentShow, dp: dp};

    seg7_decode u_decode (
        .pattern (s_q.pat),
        .bcd     (dec_bcd),
        .err     (dec_err)
    );

    // Settling FSM: s_d is the sample about to be registered, so comparing
    // it with s_q tells whether the bus held for one more edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        case (state_q)
            WAIT: begin
                if (is_active(s_q.en)) begin
                    cnt_d   = CNT_W'(1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (s_d == s_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(STABLE_CYCLES)) begin
                        cap     = 1'b1;
                        state_d = HOLD;
                    end
                end else if (!is_active(s_d.en)) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = CNT_W'(1);
                end
            end
            HOLD: begin
                // No capture here: one capture per HOLD residency.
                if (s_d != s_q) begin
                    if (is_active(s_d.en)) begin
                        cnt_d   = CNT_W'(1);
                        state_d = SETTLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
        endcase
    end

    // Slot write and frame completion. The output load uses the slot values
    // being written this edge, so the completing capture is part of the frame.
    always_comb begin
        slot_bcd_d = slot_bcd_q;
        slot_err_d = slot_err_q;
        slot_dp_d  = slot_dp_q;
        mask_d     = mask_q;
        out_bcd_d  = out_bcd_q;
        out_err_d  = out_err_q;
        out_dp_d   = out_dp_q;
        fv_d       = 1'b0;
        if (cap) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (s_q.en[i]) begin
                    slot_bcd_d[i] = dec_bcd;
                    slot_err_d[i] = dec_err;
                    slot_dp_d[i]  = s_q.dp;
                end
            end
            mask_d = mask_q | s_q.en;
            if (mask_d == {NUM_DIGITS{1'b1}}) begin
                out_bcd_d = slot_bcd_d;
                out_err_d = slot_err_d;
                out_dp_d  = slot_dp_d;
                fv_d      = 1'b1;
                mask_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q        <= '0;
            state_q    <= WAIT;
            cnt_q      <= '0;
            slot_bcd_q <= '0;
            slot_err_q <= '0;
            slot_dp_q  <= '0;
            mask_q     <= '0;
            out_bcd_q  <= '0;
            out_err_q  <= '0;
            out_dp_q   <= '0;
            fv_q       <= 1'b0;
        end else begin
            s_q        <= s_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_bcd_q <= slot_bcd_d;
            slot_err_q <= slot_err_d;
            slot_dp_q  <= slot_dp_d;
            mask_q     <= mask_d;
            out_bcd_q  <= out_bcd_d;
            out_err_q  <= out_err_d;
            out_dp_q   <= out_dp_d;
            fv_q       <= fv_d;
        end
    end

    assign bcd_out     = out_bcd_q;
    assign dp_out      = out_dp_q;
    assign digit_err   = out_err_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_segment_scan_capture.sv
module tb_segment_scan_capture;

    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s1, s2, s3, s4;
    logic [6:0]  seg;
    logic        dpi;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;
    logic [3:0]  digit_err;
    logic        frame_valid;

    segment_scan_capture #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .segment1    (s1),
        .segment2    (s2),
        .segment3    (s3),
        .segment4    (s4),
        .segmentShow (seg),
        .dp          (dpi),
        .bcd_out     (bcd_out),
        .dp_out      (dp_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    // Independent pattern table, abcdefg with a in bit 6.
    logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011};

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic [3:0]  err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int total = 0;
    int bad   = 0;
    int pulses = 0;

    // Scoreboard: every published frame must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            pulses++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_frame got bcd=%h dp=%b err=%b, no frame expected",
                         bcd_out, dp_out, digit_err);
            end else begin
                mon_e = q.pop_front();
                if ({bcd_out, dp_out, digit_err} !== {mon_e.bcd, mon_e.dp, mon_e.err}) begin
                    bad++;
                    $display("FAIL frame got bcd=%h dp=%b err=%b want bcd=%h dp=%b err=%b",
                             bcd_out, dp_out, digit_err, mon_e.bcd, mon_e.dp, mon_e.err);
                end
            end
        end
    end

    task automatic set_in(input logic [3:0] en, input logic [6:0] p, input logic d);
        {s1, s2, s3, s4} = en;
        seg = p;
        dpi = d;
    endtask

    task automatic hold(input logic [3:0] en, input logic [6:0] p, input logic d, input int n);
        @(negedge clk);
        set_in(en, p, d);
        repeat (n) @(posedge clk);
    endtask

    task automatic push(input logic [15:0] b, input logic [3:0] d, input logic [3:0] e);
        exp_t x;
        x.bcd = b; x.dp = d; x.err = e;
        q.push_back(x);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain pending=%0d want 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(4'b0000, 7'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bcd_out !== 16'h0000) begin bad++; $display("FAIL reset_bcd got %h want 0000", bcd_out); end
        total++; if (dp_out !== 4'b0) begin bad++; $display("FAIL reset_dp got %b want 0000", dp_out); end
        total++; if (digit_err !== 4'b0) begin bad++; $display("FAIL reset_err got %b want 0000", digit_err); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got %b want 0", frame_valid); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_broadcast();
        int p0;
        logic want;
        p0 = pulses;
        push(16'h1111, 4'b0000, 4'b0000);
        @(negedge clk);
        set_in(4'b1111, pat[1], 1'b0);
        // Held from edge k=1; slot written on k=1+SC, pulse seen after it.
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            want = (k == SC + 1);
            total++;
            if (frame_valid !== want) begin
                bad++;
                $display("FAIL bcast_fv_k%0d got %b want %b", k, frame_valid, want);
            end
        end
        hold(4'b0000, 7'b0, 1'b0, 4);
        drain("bcast");
        total++;
        if (pulses - p0 != 1) begin bad++; $display("FAIL bcast_pulses got %0d want 1", pulses - p0); end
    endtask

    task automatic test_scan();
        int p0;
        p0 = pulses;
        push(16'h2025, 4'b0100, 4'b0000);
        hold(4'b1000, pat[2], 1'b0, 8);
        hold(4'b0100, pat[0], 1'b1, 8);
        hold(4'b0010, pat[2], 1'b0, 8);
        hold(4'b0001, pat[5], 1'b0, 8);
        hold(4'b0000, 7'b0, 1'b0, 4);
        drain("scan");
        total++;
        if (pulses - p0 != 1) begin bad++; $display("FAIL scan_pulses got %0d want 1", pulses - p0); end
    endtask

    task automatic test_glitch();
        // Digit 3 settles on 7, then flashes 8 for SC-1 edges before moving on.
        push(16'h4576, 4'b0000, 4'b0000);
        hold(4'b1000, pat[4], 1'b0, 8);
        hold(4'b0100, pat[5], 1'b0, 8);
        hold(4'b0010, pat[7], 1'b0, 8);
        hold(4'b0010, pat[8], 1'b0, SC - 1);
        hold(4'b0001, pat[6], 1'b0, 8);
        hold(4'b0000, 7'b0, 1'b0, 4);
        drain("glitch");
    endtask

    task automatic test_invalid();
        push(16'h123F, 4'b0000, 4'b0001);
        hold(4'b1000, pat[1], 1'b0, 8);
        hold(4'b0100, pat[2], 1'b0, 8);
        hold(4'b0010, pat[3], 1'b0, 8);
        hold(4'b0001, 7'b0000000, 1'b0, 8);
        hold(4'b0000, 7'b0, 1'b0, 4);
        drain("invalid");
    endtask

    task automatic test_illegal();
        int p0;
        p0 = pulses;
        hold(4'b0110, pat[3], 1'b0, 20);
        hold(4'b0000, pat[3], 1'b0, 20);
        @(negedge clk);
        total++;
        if (pulses != p0) begin bad++; $display("FAIL illegal_pulses got %0d want 0", pulses - p0); end
        total++;
        if (bcd_out !== 16'h123F) begin bad++; $display("FAIL illegal_hold_bcd got %h want 123f", bcd_out); end
    endtask

    task automatic test_reset_mid();
        int p0;
        hold(4'b1000, pat[4], 1'b0, 8);
        hold(4'b0100, pat[5], 1'b0, 8);
        @(negedge clk);
        rst_n = 1'b0;
        set_in(4'b0000, 7'b0, 1'b0);
        #1;
        total++;
        if ({bcd_out, dp_out, digit_err, frame_valid} !== 25'd0) begin
            bad++;
            $display("FAIL midreset_async got bcd=%h dp=%b err=%b fv=%b want zeros",
                     bcd_out, dp_out, digit_err, frame_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bcd_out, dp_out, digit_err, frame_valid} !== 25'd0) begin
            bad++;
            $display("FAIL midreset_held got bcd=%h fv=%b want zeros", bcd_out, frame_valid);
        end
        rst_n = 1'b1;
        // Only digits 3 and 4 now: stale mask bits from 1 and 2 would complete a frame.
        p0 = pulses;
        hold(4'b0010, pat[7], 1'b0, 8);
        hold(4'b0001, pat[6], 1'b0, 8);
        hold(4'b0000, 7'b0, 1'b0, 6);
        total++;
        if (pulses != p0) begin bad++; $display("FAIL midreset_stale got %0d pulses want 0", pulses - p0); end
        push(16'h9876, 4'b0000, 4'b0000);
        hold(4'b1000, pat[9], 1'b0, 8);
        hold(4'b0100, pat[8], 1'b0, 8);
        hold(4'b0000, 7'b0, 1'b0, 4);
        drain("midreset");
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_scan();
        test_glitch();
        test_invalid();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
